// File: rtl/mem_pkg.sv
// Shared definitions for the line memory responder and its storage.
//   - mem_state_e : responder FSM states
//   - mem_op_e    : latched request operation
//   - line_bits / offset_bits : geometry derived from the line size in bytes
package mem_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_e;

  function automatic int unsigned line_bits(input int unsigned block_size);
    return 8 * block_size;
  endfunction

  function automatic int unsigned offset_bits(input int unsigned block_size);
    return $clog2(block_size);
  endfunction

endpackage

// File: rtl/line_storage.sv
// DEPTH x LINE_BITS line array with one synchronous write port and one read port
// whose data is registered on the cycle the read is committed.
// Ports:
//   i_clk     rising-edge clock
//   i_reset   synchronous active-high reset (clears the read register only)
//   i_we      write strobe: stores i_wdata into line i_idx
//   i_re      read strobe: loads o_rdata from line i_idx
//   i_idx     line index
//   i_wdata   line to store
//   o_rdata   last line read
module line_storage
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LINE_BITS = 512,
  localparam int unsigned IdxW     = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [IdxW-1:0]      i_idx,
  input  logic [LINE_BITS-1:0] i_wdata,
  output logic [LINE_BITS-1:0] o_rdata
);

  // Line contents survive reset on purpose.
  logic [LINE_BITS-1:0] r_mem [DEPTH];
  logic [LINE_BITS-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/line_memory_responder.sv
// Backing-memory responder for the cache line-fill/writeback interface.
// Accepts one whole-line read or write when idle, stays busy for LATENCY cycles,
// then commits the operation into line_storage.
// Ports:
//   i_clk              rising-edge clock
//   i_reset            synchronous active-high reset
//   i_mem_address      byte address of the line (offset bits ignored, index wraps)
//   i_mem_write_data   line to store
//   i_mem_read_enable  line read request
//   i_mem_write_enable line write request
//   o_mem_read_data    last line read
//   o_mem_ready        idle / previous request complete
//   o_mem_error        1-cycle pulse when both enables are seen at accept
//   o_rd_count         committed reads, saturating   (MEM_STATS_EN only)
//   o_wr_count         committed writes, saturating  (MEM_STATS_EN only)
// Build option: define MEM_STATS_EN to add the read/write commit counters.
module line_memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 4,
  localparam int unsigned LineBits  = line_bits(BLOCK_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_mem_address,
  input  logic [LineBits-1:0]   i_mem_write_data,
  input  logic                  i_mem_read_enable,
  input  logic                  i_mem_write_enable,
  output logic [LineBits-1:0]   o_mem_read_data,
  output logic                  o_mem_ready,
  output logic                  o_mem_error
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]           o_rd_count,
  output logic [31:0]           o_wr_count
`endif
);

  localparam int unsigned OffsetBits = offset_bits(BLOCK_SIZE);
  localparam int unsigned IdxBits    = $clog2(DEPTH);
  localparam int unsigned CntW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  mem_state_e r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic w_accept, w_commit;

  logic [IdxBits-1:0]  r_req_idx;
  logic [LineBits-1:0] r_req_data;
  mem_op_e             r_req_op;
  logic                r_error;

  logic w_rd_commit, w_wr_commit;
  logic [IdxBits-1:0] w_idx;
  logic w_unused_addr;

  assign w_idx         = i_mem_address[OffsetBits +: IdxBits];
  // Offset and upper address bits are deliberately dropped.
  assign w_unused_addr = ^i_mem_address;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= MEM_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_accept  = 1'b0;
    w_commit  = 1'b0;
    unique case (r_state)
      MEM_IDLE: begin
        if (i_mem_read_enable || i_mem_write_enable) begin
          w_accept  = 1'b1;
          w_cnt_d   = CntLoad;
          w_state_d = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_d = r_cnt - 1'b1;
        end else begin
          w_commit  = 1'b1;
          w_state_d = MEM_IDLE;
        end
      end
      default: w_state_d = MEM_IDLE;
    endcase
  end

  // Request registers; a simultaneous read+write is recorded as a write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_req_idx  <= '0;
      r_req_data <= '0;
      r_req_op   <= OP_RD;
      r_error    <= 1'b0;
    end else begin
      r_error <= w_accept && i_mem_read_enable && i_mem_write_enable;
      if (w_accept) begin
        r_req_idx  <= w_idx;
        r_req_data <= i_mem_write_data;
        r_req_op   <= i_mem_write_enable ? OP_WR : OP_RD;
      end
    end
  end

  // Reset on the commit cycle aborts the request.
  assign w_wr_commit = w_commit && !i_reset && (r_req_op == OP_WR);
  assign w_rd_commit = w_commit && !i_reset && (r_req_op == OP_RD);

  line_storage #(
    .DEPTH     (DEPTH),
    .LINE_BITS (LineBits)
  ) u_storage (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_wr_commit),
    .i_re    (w_rd_commit),
    .i_idx   (r_req_idx),
    .i_wdata (r_req_data),
    .o_rdata (o_mem_read_data)
  );

  assign o_mem_ready = (r_state == MEM_IDLE);
  assign o_mem_error = r_error;

`ifdef MEM_STATS_EN
  logic [31:0] r_rd_count, r_wr_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_commit && (r_rd_count != 32'hFFFF_FFFF)) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (w_wr_commit && (r_wr_count != 32'hFFFF_FFFF)) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign o_rd_count = r_rd_count;
  assign o_wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
module tb_line_memory_responder;

  localparam int unsigned LAT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  addr = '0;
  logic [511:0] wdata = '0;
  logic         rd_en = 1'b0;
  logic         wr_en = 1'b0;
  logic [511:0] rdata;
  logic         ready;
  logic         err;
`ifdef MEM_STATS_EN
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
`endif

  line_memory_responder #(
    .ADDR_WIDTH (32),
    .BLOCK_SIZE (64),
    .DEPTH      (1024),
    .LATENCY    (LAT)
  ) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_mem_address      (addr),
    .i_mem_write_data   (wdata),
    .i_mem_read_enable  (rd_en),
    .i_mem_write_enable (wr_en),
    .o_mem_read_data    (rdata),
    .o_mem_ready        (ready),
    .o_mem_error        (err)
`ifdef MEM_STATS_EN
    ,
    .o_rd_count         (rd_count),
    .o_wr_count         (wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;  // mem_read_data expected when ready returns
    logic         err;   // mem_error expected in the first busy cycle
    int           busy;  // expected number of ready-low cycles
    string        name;
  } exp_t;

  exp_t         q[$];
  int           errors = 0;
  int           checks = 0;
  logic         mon_en = 1'b0;
  logic [511:0] last_rd = '0;
  int           n_rd = 0;
  int           n_wr = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Issue one request; returns just after the accepting edge. With hold set the
  // enables stay asserted so the next accept happens as soon as ready returns.
  task automatic issue(input string name, input logic [31:0] a, input logic [511:0] d,
                       input logic r, input logic w, input logic hold,
                       input logic [511:0] exp_rd);
    exp_t e;
    int guard;
    @(negedge clk);
    addr  = a;
    wdata = d;
    rd_en = r;
    wr_en = w;
    e.data = exp_rd;
    e.err  = r & w;
    e.busy = LAT;
    e.name = name;
    q.push_back(e);
    if (r && !w) begin
      last_rd = exp_rd;
      n_rd++;
    end else begin
      n_wr++;
    end
    guard = 0;
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) fail_now({name, "_ready_wait"});
    @(posedge clk);
    #1;
    if (!hold) begin
      rd_en = 1'b0;
      wr_en = 1'b0;
    end
  endtask

  // Monitor: checks error pulse and busy length per request, and read data
  // whenever ready rises.
  initial begin : monitor
    logic prev_ready;
    int   busy;
    exp_t e;
    prev_ready = 1'b1;
    busy = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!ready) begin
          if (prev_ready) begin
            busy = 1;
            if (q.size() == 0) fail_now("unexpected_accept");
            else check({q[0].name, "_err"}, 512'(err), 512'(q[0].err));
          end else begin
            busy++;
            if (busy == 2) check("err_one_cycle", 512'(err), 512'd0);
            if (busy == 60) fail_now("busy_stuck");
          end
        end else if (!prev_ready) begin
          if (q.size() == 0) begin
            fail_now("unexpected_ready_rise");
          end else begin
            e = q.pop_front();
            check({e.name, "_busy"}, 512'(busy), 512'(e.busy));
            check({e.name, "_data"}, rdata, e.data);
          end
        end
      end
      prev_ready = ready;
    end
  end

  initial begin : stim
    exp_t e;
    int guard;
    logic [511:0] d_cafe, d_wrap, d_1234, d_prior, d_aaaa, d_five;
    d_cafe  = {16{32'hCAFEBABE}};
    d_wrap  = {16{32'h0F0F1234}};
    d_1234  = {16{32'h12345678}};
    d_prior = {16{32'h5555CCCC}};
    d_aaaa  = {16{32'hAAAABBBB}};
    d_five  = {16{32'h5A5A0001}};

    // 1: reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ready", 512'(ready), 512'd1);
    check("reset_rdata", rdata, 512'd0);
    check("reset_err", 512'(err), 512'd0);
    mon_en = 1'b1;

    // 2: write then read line 0x40
    issue("wr_1000", 32'h0000_1000, d_cafe, 1'b0, 1'b1, 1'b0, last_rd);
    issue("rd_1000", 32'h0000_1000, '0, 1'b1, 1'b0, 1'b0, d_cafe);

    // 3: wrap and offset-ignore
    issue("wr_10000", 32'h0001_0000, d_wrap, 1'b0, 1'b1, 1'b0, last_rd);
    issue("rd_0000", 32'h0000_0000, '0, 1'b1, 1'b0, 1'b0, d_wrap);
    issue("rd_1004", 32'h0000_1004, '0, 1'b1, 1'b0, 1'b0, d_cafe);

    // 4: both enables -> write only plus error pulse
    issue("both_2000", 32'h0000_2000, d_1234, 1'b1, 1'b1, 1'b0, last_rd);
    issue("rd_2000", 32'h0000_2000, '0, 1'b1, 1'b0, 1'b0, d_1234);

    // 5: enables held through BUSY, back-to-back accepts, read-after-write
    issue("hold_wr_4000", 32'h0000_4000, d_five, 1'b0, 1'b1, 1'b1, last_rd);
    issue("hold_rd_4000", 32'h0000_4000, '0, 1'b1, 1'b0, 1'b1, d_five);
    issue("hold_rd_1000a", 32'h0000_1000, '0, 1'b1, 1'b0, 1'b1, d_cafe);
    issue("hold_rd_1000b", 32'h0000_1000, '0, 1'b1, 1'b0, 1'b0, d_cafe);

    // 6: reset in the 2nd busy cycle of a write aborts it
    issue("wr_3000_prior", 32'h0000_3000, d_prior, 1'b0, 1'b1, 1'b0, last_rd);
    issue("wr_3000_abort", 32'h0000_3000, d_aaaa, 1'b0, 1'b1, 1'b0, 512'd0);
    q[q.size()-1].busy = 2;
    n_wr--;
    last_rd = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 512'(ready), 512'd1);
`ifdef MEM_STATS_EN
    check("abort_wr_count", 512'(wr_count), 512'd0);
    check("abort_rd_count", 512'(rd_count), 512'd0);
    n_rd = 0;
    n_wr = 0;
`endif
    issue("rd_3000", 32'h0000_3000, '0, 1'b1, 1'b0, 1'b0, d_prior);
    issue("wr_3000_new", 32'h0000_3000, d_aaaa, 1'b0, 1'b1, 1'b0, last_rd);
    issue("rd_3000_new", 32'h0000_3000, '0, 1'b1, 1'b0, 1'b0, d_aaaa);

    // drain the scoreboard
    guard = 0;
    while ((q.size() != 0 || !ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) fail_now("drain");
    @(negedge clk);
    check("final_err_low", 512'(err), 512'd0);
`ifdef MEM_STATS_EN
    check("rd_count", 512'(rd_count), 512'(n_rd));
    check("wr_count", 512'(wr_count), 512'(n_wr));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
